// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that lends one sequential signed multiplier to NREQ requesters,
// captures the owner's operands, returns its product, and aborts hung multiplies.
//
// state | meaning
// IDLE  | no owner; arbitrate when any req is set and the multiplier is free
// ISSUE | pulse mul_start with the latched operands; clear watchdog
// WAIT  | wait for mul_done or watchdog expiry
// RESP  | pulse rsp_valid to the owner (if it is still requesting); advance ptr
module mul_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]      rsp_data,
    output logic                    rsp_err,
    output logic                    mul_start,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic                    mul_busy,
    input  logic                    mul_done,
    input  logic [2*WIDTH-1:0]      mul_result,
    output logic [7:0]              timeouts
);

    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   pick_idx;
    logic            pick_vld;
    logic            grant_now;
    logic [WDW-1:0]  wdog;
    logic            wd_expire;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int idx;
        idx      = 0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                pick_idx = IW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign grant_now = (state == S_IDLE) && pick_vld && !mul_busy;
    assign wd_expire = (wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        rsp_valid = '0;
        case (state)
            S_IDLE: begin
                if (grant_now) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done || wd_expire) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // A requester that gave up gets nothing; the result is silently dropped.
                rsp_valid = gnt & req;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            owner    <= '0;
            gnt      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            wdog     <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            timeouts <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_now) begin
                        gnt   <= NREQ'(1) << pick_idx;
                        owner <= pick_idx;
                        mul_a <= op_a[pick_idx*WIDTH +: WIDTH];
                        mul_b <= op_b[pick_idx*WIDTH +: WIDTH];
                    end
                end
                S_ISSUE: begin
                    wdog <= '0;
                end
                S_WAIT: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (mul_done) begin
                        rsp_data <= mul_result;
                        rsp_err  <= 1'b0;
                    end else if (wd_expire) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        if (timeouts != 8'hFF) begin
                            timeouts <= timeouts + 8'd1;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    gnt <= '0;
                    ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed + randomized bench for mul_share_arbiter with a mock sequential multiplier
// and a round-robin reference model kept in plain arithmetic.
module tb_mul_share_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] op_a;
    logic [NREQ*WIDTH-1:0] op_b;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_data;
    logic                  rsp_err;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic                  mul_busy;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_result;
    logic [7:0]            timeouts;

    int vectors     = 0;
    int miscompares = 0;
    int m_ptr       = 0;
    int m_timeouts  = 0;

    int  mock_lat   = 1;
    bit  mock_hang  = 1'b0;
    bit  busy_force = 1'b0;
    int  cnt;
    int  mres;

    mul_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .op_a       (op_a),
        .op_b       (op_b),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_busy   (mul_busy),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .timeouts   (timeouts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock multiplier: done arrives mock_lat cycles after the start cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 0;
            mres <= 0;
        end else if (mul_start) begin
            cnt  <= mock_lat;
            mres <= int'($signed(mul_a)) * int'($signed(mul_b));
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
        end
    end
    assign mul_busy   = (cnt != 0) || busy_force;
    assign mul_done   = (cnt == 1) && !mock_hang;
    assign mul_result = mres;

    // Owner = set bit with the smallest forward distance from the pointer.
    function automatic int rr_pick(input logic [3:0] r, input int p);
        int best  = -1;
        int bestd = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (r[i] && ((i - p + NREQ) % NREQ) < bestd) begin
                bestd = (i - p + NREQ) % NREQ;
                best  = i;
            end
        end
        return best;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from request through RESP back to IDLE.
    task automatic op(input logic [3:0] reqv, input int lat, input bit hang,
                      input bit drop, input bit scramble);
        int          own;
        int          waitc;
        bit          err;
        int          exp_p;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        req       = reqv;
        mock_lat  = lat;
        mock_hang = hang;
        own   = rr_pick(reqv, m_ptr);
        exp_a = op_a[own*WIDTH +: WIDTH];
        exp_b = op_b[own*WIDTH +: WIDTH];
        exp_p = int'($signed(exp_a)) * int'($signed(exp_b));
        err   = hang || (lat > TIMEOUT);
        waitc = err ? TIMEOUT : lat;
        tick();
        chk("gnt_issue", 32'(gnt), 32'(1 << own));
        chk("mul_start", 32'(mul_start), 32'd1);
        chk("mul_a", 32'(mul_a), 32'(exp_a));
        chk("mul_b", 32'(mul_b), 32'(exp_b));
        if (scramble) begin
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
        end
        tick();
        chk("start_pulse", 32'(mul_start), 32'd0);
        if (drop) req[own] = 1'b0;
        repeat (waitc - 1) tick();
        chk("rsp_early", 32'(rsp_valid), 32'd0);
        tick();
        if (err && m_timeouts < 255) m_timeouts++;
        chk("rsp_valid", 32'(rsp_valid), drop ? 32'd0 : 32'(1 << own));
        if (!drop) begin
            chk("rsp_data", rsp_data, err ? 32'd0 : 32'(exp_p));
            chk("rsp_err", 32'(rsp_err), 32'(err));
        end
        chk("timeouts", 32'(timeouts), 32'(m_timeouts));
        chk("mul_a_hold", 32'(mul_a), 32'(exp_a));
        m_ptr = (own + 1) % NREQ;
        tick();
        chk("gnt_idle", 32'(gnt), 32'd0);
        chk("rsp_after", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mul_start", 32'(mul_start), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_timeouts", 32'(timeouts), 32'd0);
        rst = 1'b0;
        tick();

        // Contention: all four held, served 0,1,2,3,0.
        op_a = {16'd4, 16'd3, 16'd2, 16'd1};
        op_b = {4{16'd100}};
        repeat (5) op(4'b1111, 4, 1'b0, 1'b0, 1'b0);

        // Single request with a negative operand.
        op_a[0 +: 16] = 16'd3;
        op_b[0 +: 16] = 16'hFFFB;
        op(4'b0001, 4, 1'b0, 1'b0, 1'b0);

        // Randomized traffic, operands disturbed after each grant.
        for (int n = 0; n < 12; n++) begin
            op_a = {$urandom, $urandom};
            op_b = {$urandom, $urandom};
            op(4'($urandom_range(1, 15)), $urandom_range(1, 8), 1'b0, 1'b0, 1'b1);
        end

        // Fairness across the wrap: move ptr to 3, then 1001 serves 3 then 0.
        op(4'b0100, 2, 1'b0, 1'b0, 1'b0);
        op(4'b1001, 3, 1'b0, 1'b0, 1'b0);
        op(4'b1001, 3, 1'b0, 1'b0, 1'b0);

        // Requester 2 gives up mid-WAIT; pointer must still advance to 3.
        op(4'b0100, 5, 1'b0, 1'b1, 1'b0);
        op(4'b1100, 2, 1'b0, 1'b0, 1'b0);

        // Watchdog: hang, done exactly at expiry, done one cycle late.
        op(4'b0001, 10, 1'b1, 1'b0, 1'b0);
        op(4'b0010, TIMEOUT, 1'b0, 1'b0, 1'b0);
        op(4'b0001, TIMEOUT + 1, 1'b0, 1'b0, 1'b0);

        // Busy multiplier blocks arbitration.
        busy_force = 1'b1;
        req = 4'b0010;
        repeat (3) begin
            tick();
            chk("busy_gnt", 32'(gnt), 32'd0);
            chk("busy_start", 32'(mul_start), 32'd0);
        end
        busy_force = 1'b0;
        op(4'b0010, 3, 1'b0, 1'b0, 1'b0);

        // Reset mid-WAIT, then a fresh grant starts from requester 0.
        req = 4'b0100;
        mock_lat = 20;
        tick();
        chk("pre_rst_gnt", 32'(gnt), 32'd4);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_start", 32'(mul_start), 32'd0);
        chk("mid_rst_timeouts", 32'(timeouts), 32'd0);
        m_ptr = 0;
        m_timeouts = 0;
        tick();
        rst = 1'b0;
        op(4'b0101, 3, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
